// File: rtl/gpio_uart_tx.sv
// Serialises every change of the processor GPIO byte as an 8N1 UART frame, LSB first.
// A single-entry pending slot holds one change that arrives mid-frame; overwrites are flagged.
module gpio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] gpio_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       pend_o,
    output logic       overrun_o,
    output logic [7:0] frame_cnt_o
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 17;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   gpio_last_q, gpio_last_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    logic                chg;
    logic                bit_done;
    logic                stop_done;
    logic [IDX_W-1:0]    bit_idx_nxt;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            gpio_last_q <= '0;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            bit_idx_q   <= '0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gpio_last_q <= gpio_last_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state, line and pending-slot logic
    always_comb begin
        state_d     = state_q;
        gpio_last_d = gpio_last_q;
        shreg_d     = shreg_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        tx_d        = tx_q;
        frame_cnt_d = frame_cnt_q;
        ovr_d       = 1'b0;

        chg         = (gpio_i != gpio_last_q);
        bit_done    = (baud_q == BIT_LAST);
        stop_done   = (state_q == S_STOP) && (baud_q == STOP_LAST);
        bit_idx_nxt = bit_idx_q + IDX_W'(1);

        if (chg) begin
            gpio_last_d = gpio_i;
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (chg) begin
                    shreg_d = gpio_i;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        tx_d      = shreg_q[bit_idx_nxt];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (stop_done) begin
                    baud_d      = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (pend_vld_q) begin
                        shreg_d    = pend_q;
                        pend_vld_d = 1'b0;
                        tx_d       = 1'b0;
                        state_d    = S_START;
                    end else if (chg) begin
                        shreg_d = gpio_i;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // A mid-frame change parks in the slot; a direct load at stop end bypasses it
        if (chg && (state_q != S_IDLE)) begin
            if (stop_done && pend_vld_q) begin
                pend_d     = gpio_i;
                pend_vld_d = 1'b1;
            end else if (!stop_done) begin
                ovr_d      = pend_vld_q;
                pend_d     = gpio_i;
                pend_vld_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign pend_o      = pend_vld_q;
    assign overrun_o   = ovr_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
